// File: rtl/pe_host_io_pkg.sv
// Shared widths, frame sizes, FSM encoding and payload type for the PE host front end.
package pe_host_io_pkg;

  localparam int unsigned PEIO_DATA_WIDTH = 16;
  localparam int unsigned PEIO_LOAD_NUM   = 16;
  localparam int unsigned PEIO_OUT_NUM    = 4;

  typedef enum logic [1:0] {
    PEIO_IDLE    = 2'd0,
    PEIO_SEND    = 2'd1,
    PEIO_WAIT    = 2'd2,
    PEIO_COLLECT = 2'd3
  } peio_state_e;

  typedef struct packed {
    logic [PEIO_DATA_WIDTH-1:0] re;
    logic [PEIO_DATA_WIDTH-1:0] im;
  } cplx_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with occupancy count; pointers carry one wrap bit.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             empty;
  logic             do_wr;
  logic             do_rd;

  // Full when the wrap bits differ but the addresses match.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign count   = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/pe_host_io.sv
// Host streaming front end for one PE: buffers input frames, bursts them into the PE,
// collects the result burst and re-streams it downstream.
module pe_host_io
  import pe_host_io_pkg::*;
#(
  parameter int unsigned LOAD_NUM  = PEIO_LOAD_NUM,
  parameter int unsigned OUT_NUM   = PEIO_OUT_NUM,
  parameter int unsigned IN_DEPTH  = 2*LOAD_NUM,
  parameter int unsigned OUT_DEPTH = 2*OUT_NUM
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_in_v,
  input  logic [PEIO_DATA_WIDTH*2-1:0] s_in,
  output logic                         s_in_rdy,
  output logic                         pe_din_v,
  output logic [PEIO_DATA_WIDTH*2-1:0] pe_din,
  input  logic                         pe_dout_v,
  input  logic [PEIO_DATA_WIDTH*2-1:0] pe_dout,
  output logic                         m_out_v,
  output logic [PEIO_DATA_WIDTH*2-1:0] m_out,
  input  logic                         m_out_rdy,
  output logic                         busy,
  output logic                         err_unexp
);

  localparam int unsigned W      = PEIO_DATA_WIDTH*2;
  localparam int unsigned IN_CW  = $clog2(IN_DEPTH) + 1;
  localparam int unsigned OUT_CW = $clog2(OUT_DEPTH) + 1;
  localparam int unsigned SC_W   = $clog2(LOAD_NUM + 1);
  localparam int unsigned CC_W   = $clog2(OUT_NUM + 1);

  peio_state_e      state, state_nx;
  logic [SC_W-1:0]  send_cnt, send_cnt_nx;
  logic [CC_W-1:0]  col_cnt, col_cnt_nx;
  logic             in_pop;
  logic             out_push;
  logic             err_set;
  logic [W-1:0]     in_head;
  logic [IN_CW-1:0] in_count;
  logic [OUT_CW-1:0] out_count;
  logic             launch_ok;
  cplx_t            pe_din_q;

  sync_fifo #(.WIDTH(W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (s_in_v),
    .wr_data (s_in),
    .rd_en   (in_pop),
    .rd_data (in_head),
    .count   (in_count)
  );

  sync_fifo #(.WIDTH(W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (out_push),
    .wr_data (pe_dout),
    .rd_en   (m_out_rdy),
    .rd_data (m_out),
    .count   (out_count)
  );

  assign s_in_rdy = (in_count != IN_CW'(IN_DEPTH));
  assign m_out_v  = (out_count != '0);
  assign pe_din   = pe_din_q;

  // A frame launches only when it can run gap-free and its results are guaranteed room.
  assign launch_ok = (in_count >= IN_CW'(LOAD_NUM)) &&
                     (out_count <= OUT_CW'(OUT_DEPTH - OUT_NUM));

  always_comb begin
    state_nx    = state;
    send_cnt_nx = send_cnt;
    col_cnt_nx  = col_cnt;
    in_pop      = 1'b0;
    out_push    = 1'b0;
    err_set     = 1'b0;
    case (state)
      PEIO_IDLE: begin
        err_set = pe_dout_v;
        if (launch_ok) begin
          state_nx    = PEIO_SEND;
          send_cnt_nx = '0;
        end
      end
      PEIO_SEND: begin
        err_set = pe_dout_v;
        in_pop  = 1'b1;
        if (send_cnt == SC_W'(LOAD_NUM - 1)) begin
          state_nx    = PEIO_WAIT;
          send_cnt_nx = '0;
        end else begin
          send_cnt_nx = send_cnt + SC_W'(1);
        end
      end
      PEIO_WAIT: begin
        if (pe_dout_v) begin
          out_push = 1'b1;
          if (OUT_NUM == 1) begin
            state_nx   = PEIO_IDLE;
            col_cnt_nx = '0;
          end else begin
            state_nx   = PEIO_COLLECT;
            col_cnt_nx = CC_W'(1);
          end
        end
      end
      PEIO_COLLECT: begin
        if (pe_dout_v) begin
          out_push = 1'b1;
          if (col_cnt == CC_W'(OUT_NUM - 1)) begin
            state_nx   = PEIO_IDLE;
            col_cnt_nx = '0;
          end else begin
            col_cnt_nx = col_cnt + CC_W'(1);
          end
        end
      end
      default: state_nx = PEIO_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= PEIO_IDLE;
      send_cnt  <= '0;
      col_cnt   <= '0;
      pe_din_v  <= 1'b0;
      pe_din_q  <= '0;
      busy      <= 1'b0;
      err_unexp <= 1'b0;
    end else begin
      state     <= state_nx;
      send_cnt  <= send_cnt_nx;
      col_cnt   <= col_cnt_nx;
      pe_din_v  <= in_pop;
      pe_din_q  <= in_pop ? cplx_t'(in_head) : '0;
      busy      <= (state_nx != PEIO_IDLE);
      err_unexp <= err_unexp | err_set;
    end
  end

endmodule
